// File: rtl/clock_phase_monitor_if.sv
// ---------------------------------------------------------------------------
// clock_phase_monitor_if
//   Bundles the phase inputs, error clear and status outputs of the
//   clock phase monitor so they travel as one port.
//
//   master modport : drives phase_a / phase_b / err_clr, observes status
//   slave  modport : the monitor itself
//
//   phase_a      0 deg divided clock (asynchronous to clk)
//   phase_b      90 deg divided clock (asynchronous to clk)
//   err_clr      synchronous clear of the sticky error flag
//   phase        decoded phase index 0..3
//   tick         one-clk pulse at the start of each processor cycle
//   running      phases advancing legally
//   locked       sequence validated (running or halted)
//   cycle_count  completed processor cycles, wraps
//   err          sticky illegal-sequence flag
// ---------------------------------------------------------------------------
interface clock_phase_monitor_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 phase_a;
  logic                 phase_b;
  logic                 err_clr;
  logic [1:0]           phase;
  logic                 tick;
  logic                 running;
  logic                 locked;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic                 err;

  modport master (
    output phase_a, phase_b, err_clr,
    input  phase, tick, running, locked, cycle_count, err
  );

  modport slave (
    input  phase_a, phase_b, err_clr,
    output phase, tick, running, locked, cycle_count, err
  );
endinterface

// File: rtl/clock_phase_monitor.sv
// ---------------------------------------------------------------------------
// clock_phase_monitor
//   Receiver for the four-phase clock generator. Synchronises the two
//   quadrature phase clocks into the clk domain, decodes the phase index,
//   classifies each change as forward / backward / skip, and tracks a
//   SYNC / RUN / HALT state. Counts completed processor cycles (3->0 steps
//   while locked) and raises a sticky error on illegal sequences.
//
//   clk    fast sampling clock
//   reset  asynchronous active-low reset
//   bus    clock_phase_monitor_if.slave (phase inputs, err_clr, status)
// ---------------------------------------------------------------------------
module clock_phase_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  clock_phase_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_phase;     // last decoded index seen
  state_t                 r_state;
  logic                   r_fwd_seen;  // one forward step already seen in SYNC
  logic [7:0]             r_stall;
  logic                   r_tick;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_err;

  logic [1:0]             w_idx;
  logic [1:0]             w_step;
  logic                   w_fwd;
  logic                   w_illegal;
  state_t                 w_state_next;
  logic                   w_fwd_seen_next;
  logic [7:0]             w_stall_next;
  logic                   w_tick_next;
  logic                   w_err_set;

  // NOTE: the synchronisers are reset too, so the first decoded index after
  // reset is a defined 0 rather than whatever metastable value settled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its predecessor, which is what turns this into a shift chain.
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], bus.phase_a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.phase_b};
    end
  end

  // Gray decode of the synchronised pair: 00->0, 10->1, 11->2, 01->3.
  always_comb begin
    case ({r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]})
      2'b00:   w_idx = 2'd0;
      2'b10:   w_idx = 2'd1;
      2'b11:   w_idx = 2'd2;
      default: w_idx = 2'd3;
    endcase
  end

  // Modulo-4 difference: 0 none, 1 forward, 3 backward, 2 skip (both bits).
  assign w_step    = w_idx - r_phase;
  assign w_fwd     = (w_step == 2'd1);
  assign w_illegal = (w_step == 2'd2) || (w_step == 2'd3);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned (no latch).
    w_state_next    = r_state;
    w_fwd_seen_next = r_fwd_seen;
    w_stall_next    = r_stall;
    w_tick_next     = 1'b0;
    w_err_set       = 1'b0;

    case (r_state)
      ST_SYNC: begin
        w_stall_next = '0;
        if (w_illegal) begin
          w_fwd_seen_next = 1'b0;
        end else if (w_fwd) begin
          if (r_fwd_seen) begin
            w_state_next    = ST_RUN;
            w_fwd_seen_next = 1'b0;
          end else begin
            w_fwd_seen_next = 1'b1;
          end
        end
      end

      ST_RUN, ST_HALT: begin
        if (w_illegal) begin
          w_err_set    = 1'b1;
          w_state_next = ST_SYNC;
          w_stall_next = '0;
        end else if (w_fwd) begin
          w_state_next = ST_RUN;
          w_stall_next = '0;
          // Wrapping 3->0 marks the start of a new processor cycle.
          w_tick_next  = (r_phase == 2'd3);
        end else begin
          if (r_stall != STALL_MAX) w_stall_next = r_stall + 8'd1;
          if (r_state == ST_RUN && w_stall_next == STALL_MAX) w_state_next = ST_HALT;
        end
      end

      default: w_state_next = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase    <= 2'd0;
      r_state    <= ST_SYNC;
      r_fwd_seen <= 1'b0;
      r_stall    <= '0;
      r_tick     <= 1'b0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_phase    <= w_idx;
      r_state    <= w_state_next;
      r_fwd_seen <= w_fwd_seen_next;
      r_stall    <= w_stall_next;
      r_tick     <= w_tick_next;
      if (w_tick_next) r_count <= r_count + 1'b1;
      // A new error outranks a simultaneous clear.
      if (w_err_set)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.tick        = r_tick;
  assign bus.running     = (r_state == ST_RUN);
  assign bus.locked      = (r_state != ST_SYNC);
  assign bus.cycle_count = r_count;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_phase_monitor
//   Self-checking bench for clock_phase_monitor (counter narrowed to 4 bits
//   so the wrap is reachable). Each applied step pushes its expected status
//   onto a scoreboard queue; the record is popped and compared once the
//   step has crossed the synchroniser.
// ---------------------------------------------------------------------------
module tb_clock_phase_monitor;

  localparam int CW = 4;

  typedef struct {
    logic [1:0]    idx;      // phase index driven (also the expected phase)
    logic          clr;      // err_clr high across the detect edge
    int            hold;     // clk cycles until the next step (>= 4)
    logic          locked;
    logic          running;
    logic          err;
    logic [CW-1:0] count;
  } vec_t;

  logic clk;
  logic reset;

  clock_phase_monitor_if #(.CNT_WIDTH(CW)) ifc ();

  clock_phase_monitor #(
    .SYNC_STAGES (2),
    .STALL_LIMIT (16),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       sb_q[$];
  vec_t       table_v[42];
  logic [1:0] last_idx    = 2'd0;
  logic       last_locked = 1'b0;
  int         cyc = 0;
  int         tick_cnt = 0;
  int         last_tick_cyc = 0;
  bit         have_prev_tick = 0;
  bit         gap_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] idx, input logic clr, input int hold,
                              input logic l, input logic r, input logic e,
                              input logic [CW-1:0] c);
    vec_t v;
    v.idx = idx; v.clr = clr; v.hold = hold;
    v.locked = l; v.running = r; v.err = e; v.count = c;
    return v;
  endfunction

  // Tick monitor: sampled 1 unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ifc.tick === 1'b1) begin
      tick_cnt++;
      if (gap_en && have_prev_tick) check("tick_gap", cyc - last_tick_cyc, 32);
      last_tick_cyc  = cyc;
      have_prev_tick = 1'b1;
    end
  end

  // Drive one step, check the previous state is still shown one edge before
  // the expected latency, then pop and compare at the latency edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk); #2;
    {ifc.phase_a, ifc.phase_b} = enc(v.idx);
    sb_q.push_back(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, ".pre_phase"},  32'(ifc.phase),  32'(last_idx));
    check({tag, ".pre_locked"}, 32'(ifc.locked), 32'(last_locked));
    if (v.clr) ifc.err_clr = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    e = sb_q.pop_front();
    check({tag, ".phase"},   32'(ifc.phase),       32'(e.idx));
    check({tag, ".locked"},  32'(ifc.locked),      32'(e.locked));
    check({tag, ".running"}, 32'(ifc.running),     32'(e.running));
    check({tag, ".err"},     32'(ifc.err),         32'(e.err));
    check({tag, ".count"},   32'(ifc.cycle_count), 32'(e.count));
    last_idx    = e.idx;
    last_locked = e.locked;
    repeat (v.hold - 4) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    ifc.phase_a = 1'b0;
    ifc.phase_b = 1'b0;
    ifc.err_clr = 1'b0;

    // Clean rotation from reset: lock on step 2, one cycle per 3->0 step.
    for (int k = 1; k <= 42; k++)
      table_v[k-1] = mk(2'(k % 4), 1'b0, 8, k >= 2, k >= 2, 1'b0, CW'(k / 4));

    #45;
    check("rst.phase",   32'(ifc.phase),       0);
    check("rst.tick",    32'(ifc.tick),        0);
    check("rst.running", 32'(ifc.running),     0);
    check("rst.locked",  32'(ifc.locked),      0);
    check("rst.count",   32'(ifc.cycle_count), 0);
    check("rst.err",     32'(ifc.err),         0);
    #5 reset = 1'b1;

    gap_en = 1'b1;
    for (int i = 0; i < 42; i++) apply(table_v[i], "rot");
    gap_en = 1'b0;
    check("rot.ticks", tick_cnt, 10);

    // Halt: last change was 4 edges ago; halt exactly 16 edges after it.
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("halt.running_at15", 32'(ifc.running), 1);
    @(posedge clk);
    @(negedge clk);
    check("halt.running_at16", 32'(ifc.running), 0);
    check("halt.locked",       32'(ifc.locked),  1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("halt.still_halted", 32'(ifc.running),     0);
    check("halt.count",        32'(ifc.cycle_count), 10);
    apply(mk(2'd3, 1'b0, 8, 1, 1, 0, 4'd10), "resume3");
    apply(mk(2'd0, 1'b0, 8, 1, 1, 0, 4'd11), "resume0");
    check("resume.ticks", tick_cnt, 11);

    // Skip 0->2: error, back to SYNC, relock without a tick, then clear.
    apply(mk(2'd2, 1'b0, 8, 0, 0, 1, 4'd11), "skip");
    apply(mk(2'd3, 1'b0, 8, 0, 0, 1, 4'd11), "relock1");
    apply(mk(2'd0, 1'b0, 8, 1, 1, 1, 4'd11), "relock2");
    apply(mk(2'd1, 1'b0, 8, 1, 1, 1, 4'd11), "relock3");
    apply(mk(2'd1, 1'b1, 4, 1, 1, 0, 4'd11), "errclr");
    check("skip.ticks", tick_cnt, 11);

    // Reverse 2->1 with err_clr on the detect edge: the error wins.
    apply(mk(2'd2, 1'b0, 8, 1, 1, 0, 4'd11), "pre_rev");
    apply(mk(2'd1, 1'b1, 8, 0, 0, 1, 4'd11), "reverse");

    // Clear, relock, then run six more cycles: 17 total wraps to 1.
    apply(mk(2'd1, 1'b1, 4, 0, 0, 0, 4'd11), "errclr2");
    apply(mk(2'd2, 1'b0, 8, 0, 0, 0, 4'd11), "relock_a");
    apply(mk(2'd3, 1'b0, 8, 1, 1, 0, 4'd11), "relock_b");
    for (int j = 1; j <= 21; j++)
      apply(mk(2'((3 + j) % 4), 1'b0, 8, 1, 1, 0, CW'(11 + (j + 3) / 4)), "wrap");
    check("wrap.ticks", tick_cnt, 17);

    // Async reset for 3 units between edges: outputs clear without a clock.
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst.running", 32'(ifc.running),     0);
    check("arst.locked",  32'(ifc.locked),      0);
    check("arst.count",   32'(ifc.cycle_count), 0);
    check("arst.err",     32'(ifc.err),         0);
    check("arst.tick",    32'(ifc.tick),        0);
    check("arst.phase",   32'(ifc.phase),       0);
    #2 reset = 1'b1;
    last_idx    = 2'd0;
    last_locked = 1'b0;
    apply(mk(2'd1, 1'b0, 8, 0, 0, 0, 4'd0), "post_rst1");
    apply(mk(2'd2, 1'b0, 8, 1, 1, 0, 4'd0), "post_rst2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_phase_monitor.md
Name: clock_phase_monitor

Overview:
- Receiver for the four-phase clock generator: samples the two quadrature phase clocks on the fast raw clock, decodes the current phase, and tracks run/halt state.
- Counts completed processor cycles and flags illegal phase sequences such as glitches, skipped phases or reversed rotation.
- Feeds the front-panel status logic and the bench self-checks.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each phase input (minimum 2).
- STALL_LIMIT, 16, consecutive clk cycles without a phase change before the block declares the clock halted (range 2..255).
- CNT_WIDTH, 16, width of the processor-cycle counter.

Ports:
- clk  input  1  fast sampling clock (raw oscillator domain).
- reset  input  1  asynchronous, active-low reset.
- phase_a  input  1  0° divided clock from the generator (asynchronous to clk).
- phase_b  input  1  90° divided clock from the generator (asynchronous to clk).
- err_clr  input  1  synchronous clear of the sticky error flag.
- phase  output  2  decoded phase index 0..3.
- tick  output  1  one-clk pulse at the start of each processor cycle.
- running  output  1  1 while phases are advancing legally.
- locked  output  1  1 once the sequence is validated (RUN or HALT state).
- cycle_count  output  CNT_WIDTH  completed processor cycles, wraps.
- err  output  1  sticky illegal-sequence flag.

Behaviour:
- Reset (reset=0, async): synchroniser flops=0, state=SYNC, phase=0, tick=0, running=0, locked=0, cycle_count=0, err=0, stall counter=0.
- Decode of synchronised {a,b}: 00->0, 10->1, 11->2, 01->3. The legal forward step is idx -> idx+1 mod 4.
- Latency: an input edge appears on phase SYNC_STAGES+1 clk cycles later. tick is asserted in the same cycle phase updates.
- Transition classes, per clk, comparing new idx with the previous idx:
  - none: idx unchanged.
  - forward: new = old+1 mod 4.
  - backward: new = old-1 mod 4.
  - skip: both bits changed.
  - Backward and skip are both illegal.
- State SYNC (locked=0, running=0):
  - Two consecutive forward steps -> RUN.
  - An illegal step restarts the count. err is NOT set in SYNC.
  - No tick is generated and cycle_count is not incremented in SYNC.
- State RUN (locked=1, running=1):
  - Forward step: stall counter cleared.
  - Forward step 3->0: tick=1 for one clk and cycle_count+1, wrapping from all-ones to 0.
  - Illegal step: err=1 -> SYNC.
  - Stall counter reaches STALL_LIMIT -> HALT. The counter saturates.
- State HALT (locked=1, running=0):
  - Forward step -> RUN. Counting applies as in RUN, so a 3->0 step in HALT pulses tick.
  - Illegal step: err=1 -> SYNC.
- err is sticky until err_clr=1 at a clk edge. If err_clr and a new error occur in the same cycle, set wins and err stays 1.
- The phase output always follows the decoded idx, including in SYNC.
- Reset asserted mid-operation clears everything immediately. After release the block must relock through SYNC, which needs at least 2 forward steps.

Test Plan:
- Reset then clean rotation:
  - Stimulus: reset low 50 ns, then phases rotate one step every 8 clk.
  - Required response: locked=1 after the 2nd forward step plus 3 clk; running=1; tick pulses once per 32 clk.
  - After 10 full rotations following lock: cycle_count=10.
- Halt detect and resume:
  - Stimulus: stop the phases while locked.
  - Required response: running=0 exactly STALL_LIMIT(16) clk after the last change; locked stays 1.
  - Restart the phases: running=1 on the first forward step; cycle_count continues without loss.
- Skip error:
  - Stimulus: while in RUN, jump {a,b} 00->11.
  - Required response: err=1 and locked=0 within 4 clk; relock after 2 forward steps; err stays 1.
  - Pulse err_clr: err=0.
- Reverse rotation and set-wins:
  - Stimulus: in RUN, step 2->1 with err_clr=1 in the same detect cycle.
  - Required response: err=1; state SYNC.
- Counter wrap:
  - Stimulus: CNT_WIDTH=4, run 17 cycles.
  - Required response: cycle_count=1 with no spurious err.
- Async reset mid-run:
  - Stimulus: reset low for 3 ns between clk edges.
  - Required response: all outputs 0 immediately, without waiting for clk.
